// File: rtl/alert_ping_timer_if.sv
// Receiver-side bundle between the ping timer and its alert receivers.
// The master drives ping requests; the receivers answer with ping_ok and integrity status.
interface alert_ping_timer_if #(
  parameter int NumAlerts = 4
);
  logic [NumAlerts-1:0] ping_en_o;
  logic [NumAlerts-1:0] ping_ok_i;
  logic [NumAlerts-1:0] integ_fail_i;

  modport master (
    output ping_en_o,
    input  ping_ok_i,
    input  integ_fail_i
  );

  modport slave (
    input  ping_en_o,
    output ping_ok_i,
    output integ_fail_i
  );
endinterface

// File: rtl/alert_ping_timer.sv
// Round-robin ping scheduler for alert receivers, with ping timeout detection.
// It also keeps a sticky integrity-failure flag.
module alert_ping_timer #(
  parameter int NumAlerts = 4,
  parameter int CntW      = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         en_i,
  input  logic [NumAlerts-1:0]         alert_en_i,
  input  logic [CntW-1:0]              wait_cyc_i,
  input  logic [CntW-1:0]              timeout_cyc_i,
  input  logic                         clr_i,
  alert_ping_timer_if.master           rx,
  output logic                         ping_fail_o,
  output logic [$clog2(NumAlerts)-1:0] fail_idx_o,
  output logic                         integ_fail_o
);

  localparam int IdxW = $clog2(NumAlerts);
  localparam logic [NumAlerts-1:0] OneLsb = NumAlerts'(1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    PING
  } state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [IdxW-1:0]       lastIdx_q, lastIdx_d;
  logic [NumAlerts-1:0]  pingEn_q, pingEn_d;
  logic                  pingFail_q, pingFail_d;
  logic [IdxW-1:0]       failIdx_q, failIdx_d;
  logic                  integFail_q, integFail_d;
  logic [CntW-1:0]       cntInc;
  logic [IdxW-1:0]       nextSel;

  // First enabled channel strictly after the last pinged one, wrapping to 0.
  function automatic logic [IdxW-1:0] nextIdx(input logic [IdxW-1:0] last,
                                              input logic [NumAlerts-1:0] mask);
    logic [IdxW-1:0] res;
    logic [IdxW-1:0] candIdx;
    logic            found;
    int              cand;
    res   = last;
    found = 1'b0;
    for (int k = 1; k <= NumAlerts; k++) begin
      cand = int'(last) + k;
      if (cand >= NumAlerts) cand = cand - NumAlerts;
      candIdx = IdxW'(cand);
      if (!found && mask[candIdx]) begin
        res   = candIdx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  assign cntInc  = (cnt_q == {CntW{1'b1}}) ? cnt_q : cnt_q + CntW'(1);
  assign nextSel = nextIdx(lastIdx_q, alert_en_i);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lastIdx_d  = lastIdx_q;
    pingEn_d   = pingEn_q;
    pingFail_d = 1'b0;
    failIdx_d  = failIdx_q;

    if (!en_i) begin
      state_d  = IDLE;
      cnt_d    = '0;
      pingEn_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          pingEn_d = '0;
          if (|alert_en_i) begin
            state_d = WAIT;
            cnt_d   = '0;
          end
        end
        WAIT: begin
          pingEn_d = '0;
          if (cnt_q == wait_cyc_i) begin
            cnt_d = '0;
            if (|alert_en_i) begin
              state_d   = PING;
              lastIdx_d = nextSel;
              pingEn_d  = OneLsb << nextSel;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cntInc;
          end
        end
        PING: begin
          // An answer or a disabled channel ends the ping quietly, even on the timeout cycle.
          if (rx.ping_ok_i[lastIdx_q] || !alert_en_i[lastIdx_q]) begin
            state_d  = WAIT;
            cnt_d    = '0;
            pingEn_d = '0;
          end else if (cnt_q == timeout_cyc_i) begin
            state_d    = WAIT;
            cnt_d      = '0;
            pingEn_d   = '0;
            pingFail_d = 1'b1;
            failIdx_d  = lastIdx_q;
          end else begin
            cnt_d = cntInc;
          end
        end
        default: begin
          state_d  = IDLE;
          cnt_d    = '0;
          pingEn_d = '0;
        end
      endcase
    end
  end

  assign integFail_d = (|(rx.integ_fail_i & alert_en_i)) | (integFail_q & ~clr_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      lastIdx_q   <= IdxW'(NumAlerts - 1);
      pingEn_q    <= '0;
      pingFail_q  <= 1'b0;
      failIdx_q   <= '0;
      integFail_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lastIdx_q   <= lastIdx_d;
      pingEn_q    <= pingEn_d;
      pingFail_q  <= pingFail_d;
      failIdx_q   <= failIdx_d;
      integFail_q <= integFail_d;
    end
  end

  assign rx.ping_en_o  = pingEn_q;
  assign ping_fail_o   = pingFail_q;
  assign fail_idx_o    = failIdx_q;
  assign integ_fail_o  = integFail_q;

endmodule

// File: doc/alert_ping_timer.md
ALERT_PING_TIMER -- requirements
Module: alert_ping_timer

Interface
REQ-001 Parameter NumAlerts, default 4, number of alert receiver channels served; legal range 2..32.
REQ-002 Parameter CntW, default 16, width of wait/timeout counters.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, synchronous and active-high.
REQ-005 en_i  input  1  global ping enable; low forces IDLE.
REQ-006 alert_en_i  input  NumAlerts  per-channel enable mask; only enabled channels are pinged or monitored.
REQ-007 wait_cyc_i  input  CntW  idle cycles between pings, quasi-static.
REQ-008 timeout_cyc_i  input  CntW  max cycles to wait for ping_ok, quasi-static.
REQ-009 ping_ok_i  input  NumAlerts  per-channel ping_ok pulse from receivers.
REQ-010 integ_fail_i  input  NumAlerts  per-channel integ_fail from receivers.
REQ-011 clr_i  input  1  clears sticky integrity flag.
REQ-012 ping_en_o  output  NumAlerts  per-channel ping request level to receivers.
REQ-013 ping_fail_o  output  1  one-cycle pulse on ping timeout.
REQ-014 fail_idx_o  output  $clog2(NumAlerts)  index of last timed-out channel.
REQ-015 integ_fail_o  output  1  sticky OR of enabled integ_fail_i.

Function
REQ-016 All outputs SHALL be driven from flops; no combinational input-to-output path.
REQ-017 FSM states SHALL be IDLE, WAIT, PING.
REQ-018 IDLE: ping_en_o=0; if en_i=1 and alert_en_i!=0, next state WAIT with counter=0.
REQ-019 WAIT: counter +1 per cycle; when counter==wait_cyc_i, select channel and go PING with counter=0; wait_cyc_i=0 gives exactly one WAIT cycle.
REQ-020 Selection SHALL be round-robin: first enabled channel strictly after last-pinged index, wrapping NumAlerts-1 -> 0; last-pinged resets to NumAlerts-1, so first ping targets lowest enabled index.
REQ-021 If alert_en_i==0 at selection time, FSM SHALL return to IDLE without pinging.
REQ-022 PING: ping_en_o SHALL be one-hot at selected index from first PING cycle until exit; counter +1 per cycle.
REQ-023 PING exit on ping_ok_i[sel]=1: ping_en_o low next cycle, go WAIT, counter=0, no fail.
REQ-024 PING exit on counter==timeout_cyc_i with no ping_ok_i[sel]: ping_fail_o=1 for one cycle, fail_idx_o=sel, go WAIT.
REQ-025 ping_ok_i[sel] and timeout in same cycle: ok wins, no ping_fail_o.
REQ-026 ping_ok_i on non-selected channels, or in IDLE/WAIT, SHALL be ignored.
REQ-027 alert_en_i[sel] deasserted during PING: abort to WAIT next cycle, ping_en_o low, no fail.
REQ-028 en_i deasserted in any state: next state IDLE, ping_en_o=0, counter=0, no fail; last-pinged index retained.
REQ-029 Counter SHALL saturate at all-ones, never wrap.
REQ-030 integ_fail_o SHALL set when any (integ_fail_i & alert_en_i) bit is 1, independent of FSM state and en_i; clear on clr_i; set wins over simultaneous clr_i.
REQ-031 fail_idx_o SHALL hold its value until the next timeout.

Reset
REQ-032 While rst_i=1 at a clock edge: state=IDLE, counter=0, last-pinged=NumAlerts-1, ping_en_o=0, ping_fail_o=0, fail_idx_o=0, integ_fail_o=0.
REQ-033 Reset asserted mid-PING SHALL drop ping_en_o on the next edge with no ping_fail_o pulse.
REQ-034 ping_en_o SHALL be one-hot-or-zero in every cycle (bench assertion).

Verification
REQ-035 NumAlerts=4, alert_en_i=4'b1111, wait=2, timeout=5, receivers answer ping_ok 2 cycles after ping_en -> ping_en_o sequence 0001,0010,0100,1000,0001, no ping_fail_o.
REQ-036 alert_en_i=4'b1010, channel 3 never answers, timeout=5 -> ping_en_o[3] high exactly 6 cycles, ping_fail_o pulse, fail_idx_o=3; next ping targets channel 1.
REQ-037 ping_ok_i[sel] arrives on the cycle counter==timeout_cyc_i -> no ping_fail_o, FSM to WAIT.
REQ-038 en_i dropped during PING of channel 2 -> IDLE next cycle, ping_en_o=0, no fail; en_i re-raised -> next ping targets channel 3.
REQ-039 integ_fail_i[1] pulses with alert_en_i[1]=1 -> integ_fail_o=1 held; clr_i and integ_fail_i[1] same cycle -> stays 1; clr_i alone -> 0; integ_fail_i[0] with alert_en_i[0]=0 -> stays 0.
REQ-040 rst_i asserted in PING of channel 1 -> all outputs reset next edge; after release first ping targets channel 0.
